evt_sync_arb: RTL and testbench

- Multi-channel asynchronous event capture unit. It is the single-clock successor of the team's pulse synchroniser.
- Each of CH asynchronous inputs passes through a parametrised synchroniser and a per-channel edge/toggle detector. Detected events are queued in saturating per-channel counters.
- A round-robin arbiter presents the queued events one at a time on a valid/ready port with a channel ID.
- The block sits at the boundary where sideband events from foreign clock domains or pins enter the core clock domain.

---
 rtl/evt_sync_arb.sv | 145 ++++++++++++++
 tb/tb_evt_sync_arb.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_sync_arb.sv
// Multi-channel asynchronous event capture. Each input is synchronised and
// edge/toggle detected. Events are queued in saturating per-channel counters
// and presented one at a time through a round-robin valid/ready port.
module evt_sync_arb #(
    parameter int unsigned     CH          = 4,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     CNT_W       = 4,
    parameter logic [CH-1:0]   TOGGLE_MASK = 4'b0011
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH-1:0]           evt_in,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(CH)-1:0]   evt_id,
    output logic [CH-1:0]           ovf,
    input  logic [CH-1:0]           ovf_clr
);

    localparam int unsigned ID_W  = $clog2(CH);
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CH-1:0]    sync_q [SYNC_STAGES];
    logic [CH-1:0]    sync_out;
    logic [CH-1:0]    hist_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic             armed;
    logic [CH-1:0]    det;
    logic [CNT_W-1:0] cnt_q [CH];
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  sel;
    logic             sel_found;
    int unsigned      idx;
    logic             load;
    logic             take;
    logic [CH-1:0]    dec;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_cnt_q == ARM_DONE);
    assign load     = !evt_valid || evt_ready;
    assign take     = load && sel_found;

    // Synchroniser chain plus one history flop; hist always follows sync_out,
    // so the level seen at arming becomes the baseline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= evt_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_out;
        end
    end

    // Arming counter: suppress detection until the chain has flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
        end else if (arm_cnt_q != ARM_DONE) begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
        end
    end

    // Per-channel event detection: any edge in toggle mode, rising edge otherwise.
    always_comb begin
        det = '0;
        if (armed) begin
            det = (TOGGLE_MASK & (sync_out ^ hist_q)) |
                  (~TOGGLE_MASK & sync_out & ~hist_q);
        end
    end

    // Round-robin scan starting after the last granted channel.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(ptr_q) + k) % CH;
            if (!sel_found && (cnt_q[idx] != '0)) begin
                sel_found = 1'b1;
                sel       = ID_W'(idx);
            end
        end
    end

    // One-hot decrement for the channel being loaded into the output register.
    always_comb begin
        dec = '0;
        if (take) begin
            dec[sel] = 1'b1;
        end
    end

    // Saturating pending counters and sticky overflow flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (ovf_clr[i]) begin
                    ovf[i] <= 1'b0;
                end
                if (det[i] && !dec[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf[i] <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else if (!det[i] && dec[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Output register: reload whenever empty or accepted; id holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            ptr_q     <= ID_W'(CH - 1);
        end else if (load) begin
            if (sel_found) begin
                evt_valid <= 1'b1;
                evt_id    <= sel;
                ptr_q     <= sel;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_evt_sync_arb.sv
// Directed self-checking bench for evt_sync_arb (default parameters).
module tb_evt_sync_arb;

    logic       clk;
    logic       rst_n;
    logic [3:0] evt_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int n_vec;
    int n_err;

    evt_sync_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt_in    (evt_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1ns after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n     = 1'b0;
        evt_in    = 4'b0011;
        evt_ready = 1'b1;
        ovf_clr   = 4'b0000;
        tick(2);
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %0b expected 0", evt_valid);
        end
        n_vec++;
        if (evt_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_id: got %0d expected 0", evt_id);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (evt_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL baseline_suppress: got %0d valid cycles expected 0", bad);
        end
        n_vec++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL baseline_ovf: got %b expected 0000", ovf);
        end
    endtask

    task automatic test_single_toggle();
        int bad;
        evt_in[1] = 1'b0;
        tick(3);
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_early: got valid %0b expected 0 after E0+2", evt_valid);
        end
        tick(1);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            n_err++;
            $display("FAIL toggle_latency: got valid %0b id %0d expected valid 1 id 1",
                     evt_valid, evt_id);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (evt_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL toggle_single: got %0d extra valid cycles expected 0", bad);
        end
    endtask

    task automatic test_backpressure();
        int got;
        int bad_id;
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            evt_in[2] = 1'b1;
            tick(2);
            evt_in[2] = 1'b0;
            tick(2);
        end
        tick(4);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_err++;
            $display("FAIL bp_present: got valid %0b id %0d expected valid 1 id 2",
                     evt_valid, evt_id);
        end
        tick(3);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_err++;
            $display("FAIL bp_hold: got valid %0b id %0d expected valid 1 id 2",
                     evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        got = 0;
        bad_id = 0;
        for (int i = 0; i < 8; i++) begin
            if (evt_valid === 1'b1) begin
                got++;
                if (evt_id !== 2'd2) bad_id++;
            end
            tick(1);
        end
        n_vec++;
        if (got != 3 || bad_id != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d events (%0d wrong id) expected 3 with id 2",
                     got, bad_id);
        end
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_empty: got valid %0b expected 0", evt_valid);
        end
        got = 0;
        evt_in[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (evt_valid === 1'b1) got++;
        end
        evt_in[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (evt_valid === 1'b1) got++;
        end
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL level_held: got %0d events expected 1", got);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ids [6];
        exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd3;
        exp_ids[3] = 2'd0; exp_ids[4] = 2'd1; exp_ids[5] = 2'd3;
        // Fresh reset so ch0 has first priority.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        evt_ready = 1'b0;
        evt_in = 4'b1010;
        tick(2);
        evt_in = 4'b0010;
        tick(2);
        evt_in = 4'b1001;
        tick(6);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_err++;
            $display("FAIL rr_first: got valid %0b id %0d expected valid 1 id 0",
                     evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (evt_valid !== 1'b1 || evt_id !== exp_ids[i]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got valid %0b id %0d expected valid 1 id %0d",
                         i, evt_valid, evt_id, exp_ids[i]);
            end
            tick(1);
        end
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rr_empty: got valid %0b expected 0", evt_valid);
        end
    endtask

    task automatic test_overflow();
        int got;
        int bad_id;
        evt_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            evt_in[0] = ~evt_in[0];
            tick(2);
        end
        tick(2);
        n_vec++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_16: got %b expected 0000", ovf);
        end
        evt_in[0] = ~evt_in[0];
        tick(4);
        n_vec++;
        if (ovf !== 4'b0001) begin
            n_err++;
            $display("FAIL ovf_17: got %b expected 0001", ovf);
        end
        ovf_clr = 4'b0001;
        tick(1);
        ovf_clr = 4'b0000;
        n_vec++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_clear: got %b expected 0000", ovf);
        end
        // Clear lands in the same cycle as a fresh overflow.
        evt_in[0] = ~evt_in[0];
        tick(2);
        ovf_clr = 4'b0001;
        tick(1);
        ovf_clr = 4'b0000;
        n_vec++;
        if (ovf !== 4'b0001) begin
            n_err++;
            $display("FAIL ovf_set_wins: got %b expected 0001", ovf);
        end
        ovf_clr = 4'b0001;
        tick(1);
        ovf_clr = 4'b0000;
        tick(2);
        evt_ready = 1'b1;
        got = 0;
        bad_id = 0;
        for (int i = 0; i < 24; i++) begin
            if (evt_valid === 1'b1) begin
                got++;
                if (evt_id !== 2'd0) bad_id++;
            end
            tick(1);
        end
        n_vec++;
        if (got != 16 || bad_id != 0) begin
            n_err++;
            $display("FAIL ovf_drain: got %0d events (%0d wrong id) expected 16 with id 0",
                     got, bad_id);
        end
        n_vec++;
        if (ovf !== 4'b0000) begin
            n_err++;
            $display("FAIL ovf_after: got %b expected 0000", ovf);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        int bad_id;
        evt_ready = 1'b0;
        evt_in[0] = ~evt_in[0];
        evt_in[1] = ~evt_in[1];
        tick(5);
        n_vec++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            n_err++;
            $display("FAIL mid_present: got valid %0b id %0d expected valid 1 id 1",
                     evt_valid, evt_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async: got valid %0b expected 0", evt_valid);
        end
        tick(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (evt_valid === 1'b1) got++;
        end
        n_vec++;
        if (got != 0) begin
            n_err++;
            $display("FAIL mid_discard: got %0d events expected 0", got);
        end
        evt_in[1] = ~evt_in[1];
        got = 0;
        bad_id = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (evt_valid === 1'b1) begin
                got++;
                if (evt_id !== 2'd1) bad_id++;
            end
        end
        n_vec++;
        if (got != 1 || bad_id != 0) begin
            n_err++;
            $display("FAIL mid_new_edge: got %0d events (%0d wrong id) expected 1 with id 1",
                     got, bad_id);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_toggle();
        test_backpressure();
        test_round_robin();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
